// File: rtl/clock_pkg.sv
// Shared widths, field limits and alarm state encoding for the digital clock.
package clock_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;
    localparam int CNT_W = 8;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

    typedef enum logic {
        IDLE,
        RING
    } alarm_state_e;

endpackage

// File: rtl/hms_counter.sv
// 24 h hh:mm:ss time registers with run/hold, clamped load and wrap pulses.
module hms_counter
    import clock_pkg::*;
#(
    parameter int RESET_HOUR = 0,
    parameter int RESET_MIN  = 0,
    parameter int RESET_SEC  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             load_en,
    input  logic [HR_W-1:0]  set_hours,
    input  logic [MIN_W-1:0] set_minutes,
    input  logic [SEC_W-1:0] set_seconds,
    output logic [SEC_W-1:0] seconds,
    output logic [MIN_W-1:0] minutes,
    output logic [HR_W-1:0]  hours,
    output logic [SEC_W-1:0] nxt_seconds,
    output logic [MIN_W-1:0] nxt_minutes,
    output logic [HR_W-1:0]  nxt_hours,
    output logic             tick,
    output logic             hour_pulse,
    output logic             day_wrap,
    output logic             load_err
);

    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [HR_W-1:0]  hr_q, hr_d;
    logic             hour_pulse_q, hour_pulse_d;
    logic             day_wrap_q, day_wrap_d;
    logic             load_err_q, load_err_d;
    logic             sec_bad, min_bad, hr_bad;

    assign sec_bad = (set_seconds > SEC_MAX);
    assign min_bad = (set_minutes > MIN_MAX);
    assign hr_bad  = (set_hours > HR_MAX);

    // All carries resolve in one cycle; tick flags a real increment for the alarm match.
    always_comb begin
        sec_d        = sec_q;
        min_d        = min_q;
        hr_d         = hr_q;
        hour_pulse_d = 1'b0;
        day_wrap_d   = 1'b0;
        load_err_d   = 1'b0;
        tick         = 1'b0;
        if (load_en) begin
            sec_d      = sec_bad ? '0 : set_seconds;
            min_d      = min_bad ? '0 : set_minutes;
            hr_d       = hr_bad  ? '0 : set_hours;
            load_err_d = sec_bad | min_bad | hr_bad;
        end else if (run) begin
            tick = 1'b1;
            if (sec_q == SEC_MAX) begin
                sec_d = '0;
                if (min_q == MIN_MAX) begin
                    min_d        = '0;
                    hour_pulse_d = 1'b1;
                    if (hr_q == HR_MAX) begin
                        hr_d       = '0;
                        day_wrap_d = 1'b1;
                    end else begin
                        hr_d = hr_q + 1'b1;
                    end
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q        <= SEC_W'(RESET_SEC);
            min_q        <= MIN_W'(RESET_MIN);
            hr_q         <= HR_W'(RESET_HOUR);
            hour_pulse_q <= 1'b0;
            day_wrap_q   <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            sec_q        <= sec_d;
            min_q        <= min_d;
            hr_q         <= hr_d;
            hour_pulse_q <= hour_pulse_d;
            day_wrap_q   <= day_wrap_d;
            load_err_q   <= load_err_d;
        end
    end

    assign seconds     = sec_q;
    assign minutes     = min_q;
    assign hours       = hr_q;
    assign nxt_seconds = sec_d;
    assign nxt_minutes = min_d;
    assign nxt_hours   = hr_d;
    assign hour_pulse  = hour_pulse_q;
    assign day_wrap    = day_wrap_q;
    assign load_err    = load_err_q;

endmodule

// File: rtl/digital_clock_alarm.sv
// Digital clock top: time counter, 12 h / 24 h display decode and a single timed alarm.
module digital_clock_alarm
    import clock_pkg::*;
#(
    parameter int RESET_HOUR = 0,
    parameter int RESET_MIN  = 0,
    parameter int RESET_SEC  = 0,
    parameter int ALARM_LEN  = 60
) (
    input  logic             Clk_1sec,
    input  logic             reset,
    input  logic             run,
    input  logic             load_en,
    input  logic [HR_W-1:0]  set_hours,
    input  logic [MIN_W-1:0] set_minutes,
    input  logic [SEC_W-1:0] set_seconds,
    input  logic             mode_12h,
    input  logic             alarm_set,
    input  logic [HR_W-1:0]  alarm_hours,
    input  logic [MIN_W-1:0] alarm_minutes,
    input  logic             alarm_en,
    input  logic             alarm_ack,
    output logic [SEC_W-1:0] seconds,
    output logic [MIN_W-1:0] minutes,
    output logic [HR_W-1:0]  hours,
    output logic             pm,
    output logic             hour_pulse,
    output logic             day_wrap,
    output logic             load_err,
    output logic             alarm_ring
);

    localparam logic [CNT_W-1:0] RING_INIT = CNT_W'(ALARM_LEN - 1);

    logic [HR_W-1:0]  hr_int;
    logic [SEC_W-1:0] nxt_sec;
    logic [MIN_W-1:0] nxt_min;
    logic [HR_W-1:0]  nxt_hr;
    logic             tick;
    logic [HR_W-1:0]  alarm_hr_q, alarm_hr_d;
    logic [MIN_W-1:0] alarm_min_q, alarm_min_d;
    logic             alarm_match;
    alarm_state_e     state_q;
    logic [CNT_W-1:0] ring_cnt_q;
    logic             alarm_ring_q;

    hms_counter #(
        .RESET_HOUR(RESET_HOUR),
        .RESET_MIN (RESET_MIN),
        .RESET_SEC (RESET_SEC)
    ) u_hms (
        .clk        (Clk_1sec),
        .reset      (reset),
        .run        (run),
        .load_en    (load_en),
        .set_hours  (set_hours),
        .set_minutes(set_minutes),
        .set_seconds(set_seconds),
        .seconds    (seconds),
        .minutes    (minutes),
        .hours      (hr_int),
        .nxt_seconds(nxt_sec),
        .nxt_minutes(nxt_min),
        .nxt_hours  (nxt_hr),
        .tick       (tick),
        .hour_pulse (hour_pulse),
        .day_wrap   (day_wrap),
        .load_err   (load_err)
    );

    always_comb begin
        pm    = (hr_int >= 5'd12);
        hours = hr_int;
        if (mode_12h) begin
            if (hr_int == 5'd0) begin
                hours = 5'd12;
            end else if (hr_int > 5'd12) begin
                hours = hr_int - 5'd12;
            end
        end
    end

    always_comb begin
        alarm_hr_d  = alarm_hr_q;
        alarm_min_d = alarm_min_q;
        if (alarm_set) begin
            alarm_hr_d  = (alarm_hours > HR_MAX) ? '0 : alarm_hours;
            alarm_min_d = (alarm_minutes > MIN_MAX) ? '0 : alarm_minutes;
        end
    end

    always_ff @(posedge Clk_1sec) begin
        if (reset) begin
            alarm_hr_q  <= '0;
            alarm_min_q <= '0;
        end else begin
            alarm_hr_q  <= alarm_hr_d;
            alarm_min_q <= alarm_min_d;
        end
    end

    // Matching on the next-state time lets the ring start in the same cycle 07:00:00 appears.
    assign alarm_match = alarm_en && tick && (nxt_sec == '0) &&
                         (nxt_min == alarm_min_q) && (nxt_hr == alarm_hr_q);

    always_ff @(posedge Clk_1sec) begin
        if (reset) begin
            state_q      <= IDLE;
            ring_cnt_q   <= '0;
            alarm_ring_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (alarm_match) begin
                        state_q      <= RING;
                        ring_cnt_q   <= RING_INIT;
                        alarm_ring_q <= 1'b1;
                    end
                end
                RING: begin
                    if ((ring_cnt_q == '0) || alarm_ack || !alarm_en) begin
                        state_q      <= IDLE;
                        ring_cnt_q   <= '0;
                        alarm_ring_q <= 1'b0;
                    end else begin
                        ring_cnt_q <= ring_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    ring_cnt_q   <= '0;
                    alarm_ring_q <= 1'b0;
                end
            endcase
        end
    end

    assign alarm_ring = alarm_ring_q;

endmodule

// File: tb/tb_digital_clock_alarm.sv
// Scoreboard bench for digital_clock_alarm: a seconds-of-day reference model predicts every cycle.
module tb_digital_clock_alarm;

    localparam int RST_H   = 23;
    localparam int RST_M   = 59;
    localparam int RST_S   = 58;
    localparam int ALEN    = 3;
    localparam int DAY_SEC = 86400;

    typedef struct {
        logic       reset, run, load_en, mode_12h, alarm_set, alarm_en, alarm_ack;
        logic [4:0] sh;
        logic [5:0] sm, ss;
        logic [4:0] ah;
        logic [5:0] am;
    } stim_t;

    typedef struct {
        int sec, min, hrs, pm, hp, dw, le, ring;
    } exp_t;

    logic       clk;
    logic       reset, run, load_en, mode_12h, alarm_set, alarm_en, alarm_ack;
    logic [4:0] set_hours, alarm_hours, hours;
    logic [5:0] set_minutes, set_seconds, alarm_minutes, seconds, minutes;
    logic       pm, hour_pulse, day_wrap, load_err, alarm_ring;

    stim_t cur;
    exp_t  sbq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;

    // Reference model state: time as seconds of day, ring as cycles left to stay high.
    int m_t, m_ahr, m_amin, m_left, m_hp, m_dw, m_le;

    digital_clock_alarm #(
        .RESET_HOUR(RST_H),
        .RESET_MIN (RST_M),
        .RESET_SEC (RST_S),
        .ALARM_LEN (ALEN)
    ) dut (
        .Clk_1sec     (clk),
        .reset        (reset),
        .run          (run),
        .load_en      (load_en),
        .set_hours    (set_hours),
        .set_minutes  (set_minutes),
        .set_seconds  (set_seconds),
        .mode_12h     (mode_12h),
        .alarm_set    (alarm_set),
        .alarm_hours  (alarm_hours),
        .alarm_minutes(alarm_minutes),
        .alarm_en     (alarm_en),
        .alarm_ack    (alarm_ack),
        .seconds      (seconds),
        .minutes      (minutes),
        .hours        (hours),
        .pm           (pm),
        .hour_pulse   (hour_pulse),
        .day_wrap     (day_wrap),
        .load_err     (load_err),
        .alarm_ring   (alarm_ring)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic modelStep(input stim_t s);
        int  nt, h, m, sc;
        bit  inc;
        nt  = m_t;
        inc = 1'b0;
        if (s.reset) begin
            m_t    = RST_H * 3600 + RST_M * 60 + RST_S;
            m_ahr  = 0;
            m_amin = 0;
            m_left = 0;
            m_hp   = 0;
            m_dw   = 0;
            m_le   = 0;
        end else begin
            m_hp = 0;
            m_dw = 0;
            m_le = 0;
            if (s.load_en) begin
                h    = (int'(s.sh) > 23) ? 0 : int'(s.sh);
                m    = (int'(s.sm) > 59) ? 0 : int'(s.sm);
                sc   = (int'(s.ss) > 59) ? 0 : int'(s.ss);
                m_le = (int'(s.sh) > 23 || int'(s.sm) > 59 || int'(s.ss) > 59) ? 1 : 0;
                nt   = h * 3600 + m * 60 + sc;
            end else if (s.run) begin
                inc  = 1'b1;
                nt   = (m_t + 1) % DAY_SEC;
                m_hp = (nt % 3600 == 0) ? 1 : 0;
                m_dw = (nt == 0) ? 1 : 0;
            end
            if (m_left > 0) begin
                m_left = (s.alarm_ack || !s.alarm_en) ? 0 : m_left - 1;
            end else if (s.alarm_en && inc && nt == m_ahr * 3600 + m_amin * 60) begin
                m_left = ALEN;
            end
            if (s.alarm_set) begin
                m_ahr  = (int'(s.ah) > 23) ? 0 : int'(s.ah);
                m_amin = (int'(s.am) > 59) ? 0 : int'(s.am);
            end
            m_t = nt;
        end
    endtask

    function automatic exp_t predict(input logic mode12);
        exp_t e;
        int   hr;
        hr     = m_t / 3600;
        e.sec  = m_t % 60;
        e.min  = (m_t / 60) % 60;
        e.hrs  = mode12 ? ((hr % 12 == 0) ? 12 : hr % 12) : hr;
        e.pm   = (hr >= 12) ? 1 : 0;
        e.hp   = m_hp;
        e.dw   = m_dw;
        e.le   = m_le;
        e.ring = (m_left > 0) ? 1 : 0;
        return e;
    endfunction

    // Drive on the falling edge, predict at the rising edge, compare on the next falling edge.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        reset         = s.reset;
        run           = s.run;
        load_en       = s.load_en;
        mode_12h      = s.mode_12h;
        alarm_set     = s.alarm_set;
        alarm_en      = s.alarm_en;
        alarm_ack     = s.alarm_ack;
        set_hours     = s.sh;
        set_minutes   = s.sm;
        set_seconds   = s.ss;
        alarm_hours   = s.ah;
        alarm_minutes = s.am;
        @(posedge clk);
        modelStep(s);
        sbq.push_back(predict(s.mode_12h));
        @(negedge clk);
        cyc++;
        if (sbq.size() == 0) begin
            checkOutput($sformatf("c%0d.sb_empty", cyc), 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            checkOutput($sformatf("c%0d.seconds", cyc), 32'(seconds), e.sec);
            checkOutput($sformatf("c%0d.minutes", cyc), 32'(minutes), e.min);
            checkOutput($sformatf("c%0d.hours", cyc), 32'(hours), e.hrs);
            checkOutput($sformatf("c%0d.pm", cyc), 32'(pm), e.pm);
            checkOutput($sformatf("c%0d.hour_pulse", cyc), 32'(hour_pulse), e.hp);
            checkOutput($sformatf("c%0d.day_wrap", cyc), 32'(day_wrap), e.dw);
            checkOutput($sformatf("c%0d.load_err", cyc), 32'(load_err), e.le);
            checkOutput($sformatf("c%0d.alarm_ring", cyc), 32'(alarm_ring), e.ring);
        end
    endtask

    task automatic step();
        applyStimulus(cur);
        cur.reset     = 1'b0;
        cur.load_en   = 1'b0;
        cur.alarm_set = 1'b0;
        cur.alarm_ack = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic doLoad(input int h, input int m, input int s);
        cur.load_en = 1'b1;
        cur.sh      = 5'(h);
        cur.sm      = 6'(m);
        cur.ss      = 6'(s);
        step();
    endtask

    task automatic setAlarm(input int h, input int m);
        cur.alarm_set = 1'b1;
        cur.ah        = 5'(h);
        cur.am        = 6'(m);
    endtask

    initial begin
        cur = '{reset: 1'b1, run: 1'b0, load_en: 1'b0, mode_12h: 1'b0, alarm_set: 1'b0,
                alarm_en: 1'b0, alarm_ack: 1'b0, sh: 5'd0, sm: 6'd0, ss: 6'd0,
                ah: 5'd0, am: 6'd0};
        $display("[TB] reset and day wrap");
        step();
        cur.run = 1'b1;
        steps(4);

        $display("[TB] out-of-range load while running");
        doLoad(25, 30, 61);
        steps(2);
        doLoad(12, 60, 5);
        step();

        $display("[TB] 12 h / 24 h decode");
        cur.run = 1'b0;
        for (int md = 1; md >= 0; md--) begin
            cur.mode_12h = 1'(md);
            doLoad(0, 0, 0);
            doLoad(12, 0, 0);
            doLoad(13, 5, 0);
            doLoad(11, 59, 59);
            doLoad(23, 59, 59);
        end

        $display("[TB] alarm timeout");
        setAlarm(7, 0);
        step();
        cur.alarm_en = 1'b1;
        doLoad(6, 59, 58);
        cur.run = 1'b1;
        steps(8);

        $display("[TB] alarm acknowledge");
        doLoad(6, 59, 58);
        steps(2);
        cur.alarm_ack = 1'b1;
        step();
        steps(3);

        $display("[TB] alarm disabled at match, and load onto alarm time");
        cur.alarm_en = 1'b0;
        doLoad(6, 59, 58);
        steps(4);
        cur.alarm_en = 1'b1;
        doLoad(7, 0, 0);
        steps(3);

        $display("[TB] alarm_set in match cycle and clamped alarm_set");
        doLoad(6, 59, 59);
        setAlarm(8, 0);
        step();
        steps(4);
        setAlarm(30, 70);
        step();
        doLoad(23, 59, 58);
        steps(4);

        $display("[TB] disable during ring, then hold");
        setAlarm(7, 0);
        doLoad(6, 59, 59);
        step();
        cur.alarm_en = 1'b0;
        step();
        cur.alarm_en = 1'b1;
        cur.run = 1'b0;
        steps(5);

        $display("[TB] reset mid-ring");
        doLoad(6, 59, 59);
        cur.run = 1'b1;
        steps(2);
        cur.reset = 1'b1;
        step();
        steps(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
